// File: rtl/add_round_key_stream.sv
// AES AddRoundKey over a byte-lane stream: each 16-byte block is XORed with a stored round key.
// The key is snapshotted on the first beat and held for the whole block; the output is a single registered stage.
module add_round_key_stream #(
    parameter int LANES    = 4,
    parameter int NUM_KEYS = 15,
    parameter int IDXW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_wr_en,
    input  logic [IDXW-1:0]      key_wr_idx,
    input  logic [127:0]         key_wr_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [IDXW-1:0]      in_key_idx,
    input  logic                 in_bypass,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_last,
    output logic [15:0]          block_cnt,
    output logic                 err_key
);

    localparam int BEATS = 16 / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = 8 * LANES;
    localparam logic [IDXW:0] NUM_KEYS_W = (IDXW+1)'(NUM_KEYS);

    logic [127:0]  key_mem_q [NUM_KEYS];
    logic [127:0]  key_mem_d [NUM_KEYS];
    logic [BW-1:0] beat_q, beat_d;
    logic [127:0]  snap_key_q, snap_key_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [15:0]   block_cnt_q, block_cnt_d;
    logic          err_key_q, err_key_d;

    logic          in_fire, out_fire, first_beat, last_beat, idx_ok, wr_ok;
    logic [127:0]  sel_key, cur_key;
    logic [DW-1:0] key_beat;

    // Bypass and out-of-range slots both collapse to an all-zero key, so one snapshot register covers them.
    always_comb begin
        in_ready   = !out_valid_q || out_ready;
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid_q && out_ready;
        first_beat = (beat_q == '0);
        last_beat  = (beat_q == BW'(BEATS - 1));
        idx_ok     = {1'b0, in_key_idx} < NUM_KEYS_W;
        wr_ok      = {1'b0, key_wr_idx} < NUM_KEYS_W;

        sel_key = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (in_key_idx == IDXW'(i)) begin
                sel_key = key_mem_q[i];
            end
        end
        if (in_bypass) begin
            sel_key = '0;
        end

        cur_key  = first_beat ? sel_key : snap_key_q;
        key_beat = cur_key[DW*int'(beat_q) +: DW];
    end

    always_comb begin
        key_mem_d = key_mem_q;
        if (key_wr_en && wr_ok) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_wr_idx == IDXW'(i)) begin
                    key_mem_d[i] = key_wr_data;
                end
            end
        end
    end

    always_comb begin
        beat_d      = beat_q;
        snap_key_d  = snap_key_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_key_d   = err_key_q;
        block_cnt_d = block_cnt_q;

        if (out_fire && out_last_q) begin
            block_cnt_d = block_cnt_q + 16'd1;
        end

        if (in_fire) begin
            beat_d      = last_beat ? '0 : beat_q + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ key_beat;
            out_last_d  = last_beat;
            if (first_beat) begin
                snap_key_d = sel_key;
                if (!idx_ok) begin
                    err_key_d = 1'b1;
                end
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem_q[i] <= '0;
            end
            beat_q      <= '0;
            snap_key_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            block_cnt_q <= '0;
            err_key_q   <= 1'b0;
        end else begin
            key_mem_q   <= key_mem_d;
            beat_q      <= beat_d;
            snap_key_q  <= snap_key_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            block_cnt_q <= block_cnt_d;
            err_key_q   <= err_key_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign block_cnt = block_cnt_q;
    assign err_key   = err_key_q;

endmodule

// File: tb/tb_add_round_key_stream.sv
// Directed bench for add_round_key_stream: FIPS-197 round-0 vector, bypass, stalls,
// key-write collision, bad key index and mid-block reset at LANES = 4, 1 and 16.
module tb_add_round_key_stream;

   // Vectors packed with byte k at bits [8k+7:8k]
   localparam logic [127:0] KEY_VEC   = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
   localparam logic [127:0] STATE_VEC = 128'h340737e0_a2983131_8d305a88_a8f64332;
   localparam logic [127:0] OUT_VEC   = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
   localparam logic [127:0] INV_VEC   = 128'hcbf8c81f_5d67cece_72cfa577_5709bccd;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic keyWrEn = 1'b0;
   logic [3:0] keyWrIdx = '0;
   logic [127:0] keyWrData = '0;

   logic inValid4 = 1'b0, inReady4, inBypass4 = 1'b0, outValid4, outReady4 = 1'b1, outLast4, errKey4;
   logic [31:0] inData4 = '0, outData4;
   logic [3:0] inKeyIdx4 = '0;
   logic [15:0] blockCnt4;

   logic inValid1 = 1'b0, inReady1, outValid1, outLast1, errKey1;
   logic [7:0] inData1 = '0, outData1;
   logic [15:0] blockCnt1;

   logic inValid16 = 1'b0, inReady16, outValid16, outLast16, errKey16;
   logic [127:0] inData16 = '0, outData16;
   logic [15:0] blockCnt16;

   logic [32:0] q4 [$];
   logic [8:0] q1 [$];
   logic [128:0] q16 [$];

   int assertCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   add_round_key_stream #(.LANES(4), .NUM_KEYS(15), .IDXW(4)) dut4 (
      .clk(clk), .rst(rst), .key_wr_en(keyWrEn), .key_wr_idx(keyWrIdx), .key_wr_data(keyWrData),
      .in_valid(inValid4), .in_ready(inReady4), .in_data(inData4), .in_key_idx(inKeyIdx4),
      .in_bypass(inBypass4), .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
      .out_last(outLast4), .block_cnt(blockCnt4), .err_key(errKey4));

   add_round_key_stream #(.LANES(1), .NUM_KEYS(15), .IDXW(4)) dut1 (
      .clk(clk), .rst(rst), .key_wr_en(keyWrEn), .key_wr_idx(keyWrIdx), .key_wr_data(keyWrData),
      .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1), .in_key_idx(4'd0),
      .in_bypass(1'b0), .out_valid(outValid1), .out_ready(1'b1), .out_data(outData1),
      .out_last(outLast1), .block_cnt(blockCnt1), .err_key(errKey1));

   add_round_key_stream #(.LANES(16), .NUM_KEYS(15), .IDXW(4)) dut16 (
      .clk(clk), .rst(rst), .key_wr_en(keyWrEn), .key_wr_idx(keyWrIdx), .key_wr_data(keyWrData),
      .in_valid(inValid16), .in_ready(inReady16), .in_data(inData16), .in_key_idx(4'd0),
      .in_bypass(1'b0), .out_valid(outValid16), .out_ready(1'b1), .out_data(outData16),
      .out_last(outLast16), .block_cnt(blockCnt16), .err_key(errKey16));

   // Record every output beat that will be consumed at the next rising edge
   always @(negedge clk) begin
      if (outValid4 && outReady4) q4.push_back({outLast4, outData4});
      if (outValid1) q1.push_back({outLast1, outData1});
      if (outValid16) q16.push_back({outLast16, outData16});
   end

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Offer one beat to the LANES=4 instance and return #1 after the edge that accepted it
   task automatic applyStimulus(input logic [31:0] data, input logic [3:0] idx, input logic byp);
      int waited;
      waited = 0;
      inValid4 = 1'b1;
      inData4 = data;
      inKeyIdx4 = idx;
      inBypass4 = byp;
      @(negedge clk);
      while (!inReady4 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) checkOutput("in_ready_timeout", inReady4, 1);
      @(posedge clk);
      #1;
      inValid4 = 1'b0;
   endtask

   // Key index and bypass only matter on the first beat; later beats carry slot 0 on purpose
   task automatic sendBlock4(input logic [127:0] vec, input logic [3:0] idx, input logic byp);
      for (int b = 0; b < 4; b++) begin
         if (b == 0) applyStimulus(vec[32*b +: 32], idx, byp);
         else applyStimulus(vec[32*b +: 32], 4'd0, 1'b0);
      end
   endtask

   task automatic checkBlock4(input string tag, input logic [127:0] expVec);
      logic [32:0] entry;
      checkOutput({tag, "_beats"}, q4.size(), 4);
      for (int b = 0; b < 4; b++) begin
         entry = '0;
         if (q4.size() > 0) entry = q4.pop_front();
         checkOutput($sformatf("%s_beat%0d", tag, b), entry, {b == 3, expVec[32*b +: 32]});
      end
      q4.delete();
   endtask

   task automatic drive1(input logic [7:0] data);
      inValid1 = 1'b1;
      inData1 = data;
      @(posedge clk);
      #1;
      inValid1 = 1'b0;
   endtask

   task automatic drive16(input logic [127:0] data);
      inValid16 = 1'b1;
      inData16 = data;
      @(posedge clk);
      #1;
      inValid16 = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Main directed sequence
   initial begin
      logic [8:0] entry1;
      logic [128:0] entry16;

      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out", {outValid4, outLast4, outData4}, '0);
      checkOutput("reset_block_cnt", blockCnt4, 0);
      checkOutput("reset_err_key", errKey4, 0);
      checkOutput("reset_in_ready", inReady4, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", inReady4, 1);
      @(posedge clk);
      #1;

      keyWrEn = 1'b1;
      keyWrIdx = 4'd0;
      keyWrData = KEY_VEC;
      @(posedge clk);
      #1 keyWrEn = 1'b0;

      sendBlock4(STATE_VEC, 4'd0, 1'b0);
      settle();
      checkBlock4("fips", OUT_VEC);
      checkOutput("block_cnt_1", blockCnt4, 1);

      sendBlock4(STATE_VEC, 4'd0, 1'b1);
      settle();
      checkBlock4("bypass", STATE_VEC);
      checkOutput("block_cnt_2", blockCnt4, 2);

      applyStimulus(STATE_VEC[31:0], 4'd0, 1'b0);
      applyStimulus(STATE_VEC[63:32], 4'd0, 1'b0);
      outReady4 = 1'b0;
      inValid4 = 1'b1;
      inData4 = STATE_VEC[95:64];
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("stall_ready%0d", c), inReady4, 0);
         checkOutput($sformatf("stall_hold%0d", c), {outValid4, outLast4, outData4}, {1'b1, 1'b0, OUT_VEC[63:32]});
      end
      @(posedge clk);
      #1 outReady4 = 1'b1;
      applyStimulus(STATE_VEC[95:64], 4'd0, 1'b0);
      applyStimulus(STATE_VEC[127:96], 4'd0, 1'b0);
      settle();
      checkBlock4("stall", OUT_VEC);
      checkOutput("block_cnt_3", blockCnt4, 3);

      keyWrEn = 1'b1;
      keyWrIdx = 4'd0;
      keyWrData = '1;
      applyStimulus(STATE_VEC[31:0], 4'd0, 1'b0);
      keyWrEn = 1'b0;
      for (int b = 1; b < 4; b++) applyStimulus(STATE_VEC[32*b +: 32], 4'd0, 1'b0);
      settle();
      checkBlock4("old_key", OUT_VEC);
      checkOutput("block_cnt_4", blockCnt4, 4);

      sendBlock4(STATE_VEC, 4'd0, 1'b0);
      settle();
      checkBlock4("new_key", INV_VEC);
      checkOutput("block_cnt_5", blockCnt4, 5);
      checkOutput("err_key_clear", errKey4, 0);

      sendBlock4(STATE_VEC, 4'd15, 1'b0);
      settle();
      checkBlock4("bad_idx", STATE_VEC);
      checkOutput("err_key_set", errKey4, 1);

      sendBlock4(STATE_VEC, 4'd0, 1'b0);
      settle();
      checkBlock4("after_bad", INV_VEC);
      checkOutput("err_key_sticky", errKey4, 1);
      checkOutput("block_cnt_7", blockCnt4, 7);

      applyStimulus(STATE_VEC[31:0], 4'd0, 1'b0);
      applyStimulus(STATE_VEC[63:32], 4'd0, 1'b0);
      drive1(STATE_VEC[7:0]);
      drive1(STATE_VEC[15:8]);
      drive16(STATE_VEC);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_out4", {outValid4, outLast4, outData4}, '0);
      checkOutput("midrst_cnt4", blockCnt4, 0);
      checkOutput("midrst_err4", errKey4, 0);
      checkOutput("midrst_ready4", inReady4, 1);
      checkOutput("midrst_out1", {outValid1, outLast1, outData1, blockCnt1}, '0);
      checkOutput("midrst_out16", {outValid16, outLast16, outData16, blockCnt16}, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      q4.delete();
      q1.delete();
      q16.delete();

      sendBlock4(STATE_VEC, 4'd0, 1'b0);
      settle();
      checkBlock4("post_reset4", STATE_VEC);
      checkOutput("post_reset_cnt4", blockCnt4, 1);

      for (int b = 0; b < 16; b++) drive1(STATE_VEC[8*b +: 8]);
      settle();
      checkOutput("post_reset1_beats", q1.size(), 16);
      for (int b = 0; b < 16; b++) begin
         entry1 = '0;
         if (q1.size() > 0) entry1 = q1.pop_front();
         checkOutput($sformatf("post_reset1_beat%0d", b), entry1, {b == 15, STATE_VEC[8*b +: 8]});
      end
      checkOutput("post_reset_cnt1", blockCnt1, 1);

      drive16(STATE_VEC);
      drive16(INV_VEC);
      settle();
      checkOutput("post_reset16_beats", q16.size(), 2);
      entry16 = '0;
      if (q16.size() > 0) entry16 = q16.pop_front();
      checkOutput("post_reset16_beat0", entry16, {1'b1, STATE_VEC});
      entry16 = '0;
      if (q16.size() > 0) entry16 = q16.pop_front();
      checkOutput("post_reset16_beat1", entry16, {1'b1, INV_VEC});
      checkOutput("post_reset_cnt16", blockCnt16, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
